// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the add/sub issue controller.
//   DATA_W / LANE_W / LANES describe the packed dual-lane 4-bit operand format.
//   OP_ADD / OP_SUB are the only op codes forwarded to the arithmetic unit.
//   state_e is the controller sequencing state.
//   LANE_MAX / LANE_MIN are the saturation values used when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  localparam int DATA_W = 8;
  localparam int LANE_W = 4;
  localparam int LANES  = 2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_issue_ctrl_if.sv
// addsub_issue_ctrl_if: request and response handshake bundle.
//   req_valid/req_ready/req_in1/req_in2/req_op : operand request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_ovf/rsp_err : result response channel
//   slave  : controller side (consumes requests, produces responses)
//   master : requester side
interface addsub_issue_ctrl_if;
  import addsub_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_in1;
  logic [DATA_W-1:0] req_in2;
  logic [1:0]        req_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [LANES-1:0]  rsp_ovf;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_in1, req_in2, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport master (
    output req_valid, req_in1, req_in2, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/addsub_lane_chk.sv
// addsub_lane_chk: per-lane signed overflow detection and result shaping.
//   a, c : lane operands (two's complement), r : lane result from the unit
//   op   : registered op select (only OP_ADD / OP_SUB reach here)
//   ovf  : signed overflow of a op c as observed in r
//   res  : r, or the saturated lane value when ADDSUB_SAT_EN is defined
// Purely combinational.
module addsub_lane_chk
  import addsub_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] c,
  input  logic [LANE_W-1:0] r,
  input  logic [1:0]        op,
  output logic              ovf,
  output logic [LANE_W-1:0] res
);

  logic sa;
  logic sc;
  logic sr;

  assign sa = a[LANE_W-1];
  assign sc = c[LANE_W-1];
  assign sr = r[LANE_W-1];

  always_comb begin
    ovf = 1'b0;
    if (op == OP_SUB) begin
      // a - c overflows only when the operands differ in sign
      ovf = (sa != sc) && (sr != sa);
    end else begin
      ovf = (sa == sc) && (sr != sa);
    end
  end

`ifdef ADDSUB_SAT_EN
  // Overflow direction follows the sign of a: positive a can only overflow upward.
  assign res = ovf ? (sa ? LANE_MIN : LANE_MAX) : r;
`else
  assign res = r;
`endif

endmodule

// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl: issue/capture sequencer for the packed dual-lane 4-bit
// signed add/sub unit.
//   clk, rst  : clock (rising edge) and synchronous active-high reset
//   bus       : request/response handshakes (slave modport)
//   au_in1/2  : registered operands to the unit, au_op : registered op select
//   au_out    : unit result, sampled only on the capture edge
//   busy      : controller not idle
//   op_count  : completed response handshakes, wrapping
// A request is registered into the unit, the result is captured exactly
// SETTLE_CYCLES edges later (legal range 1..15) and returned with per-lane
// overflow and an illegal-op flag.
// Optional macro ADDSUB_SAT_EN: saturate overflowing lanes in rsp_data.
module addsub_issue_ctrl
  import addsub_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int OP_CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  addsub_issue_ctrl_if.slave  bus,
  output logic [DATA_W-1:0]   au_in1,
  output logic [DATA_W-1:0]   au_in2,
  output logic [1:0]          au_op,
  input  logic [DATA_W-1:0]   au_out,
  output logic                busy,
  output logic [OP_CNT_W-1:0] op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   au_in1_q, au_in1_d;
  logic [DATA_W-1:0]   au_in2_q, au_in2_d;
  logic [1:0]          au_op_q, au_op_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [LANES-1:0]    rsp_ovf_q, rsp_ovf_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OP_CNT_W-1:0] op_count_q, op_count_d;

  logic                req_ready;
  logic                accept;
  logic                rsp_hs;
  logic [LANES-1:0]    lane_ovf;
  logic [DATA_W-1:0]   lane_res;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    addsub_lane_chk u_chk (
      .a   (au_in1_q[gi*LANE_W +: LANE_W]),
      .c   (au_in2_q[gi*LANE_W +: LANE_W]),
      .r   (au_out[gi*LANE_W +: LANE_W]),
      .op  (au_op_q),
      .ovf (lane_ovf[gi]),
      .res (lane_res[gi*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    // Ready in RESP only when the pending response leaves on this edge,
    // which makes back-to-back issue possible.
    req_ready = ~rst & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
    accept    = bus.req_valid & req_ready;
    rsp_hs    = rsp_valid_q & bus.rsp_ready;

    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    au_in1_d    = au_in1_q;
    au_in2_d    = au_in2_q;
    au_op_d     = au_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;

    if (accept) begin
      au_in1_d = bus.req_in1;
      au_in2_d = bus.req_in2;
      // Illegal ops still run through the unit as an add so timing is
      // identical; the result is discarded at capture.
      au_op_d  = op_is_legal(bus.req_op) ? bus.req_op : OP_ADD;
      err_d    = ~op_is_legal(bus.req_op);
      cnt_d    = SETTLE_LOAD;
      state_d  = WAIT;
    end

    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = err_q ? '0 : lane_res;
          rsp_ovf_d   = err_q ? '0 : lane_ovf;
          rsp_err_d   = err_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          op_count_d  = op_count_q + OP_CNT_W'(1);
          rsp_valid_d = 1'b0;
          if (!accept) begin
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      au_in1_q    <= '0;
      au_in2_q    <= '0;
      au_op_q     <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      au_in1_q    <= au_in1_d;
      au_in2_q    <= au_in2_d;
      au_op_q     <= au_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign au_in1        = au_in1_q;
  assign au_in2        = au_in2_q;
  assign au_op         = au_op_q;
  assign busy          = (state_q != IDLE);
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// tb_addsub_issue_ctrl: bench for addsub_issue_ctrl (SETTLE_CYCLES=3, OP_CNT_W=4).
// A transaction-level model (in-flight flag, due cycle, integer lane math)
// predicts every DUT output each cycle. The add/sub unit is emulated from the
// model's own operand copy and drives a correct result only during the cycle
// before the expected capture edge; other cycles see random junk.
// Honours ADDSUB_SAT_EN the same way as the design.
module tb_addsub_issue_ctrl;

  localparam int SETTLE = 3;
  localparam int OP_W   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      au_in1, au_in2, au_out;
  logic [1:0]      au_op;
  logic            busy;
  logic [OP_W-1:0] op_count;

  addsub_issue_ctrl_if bus ();

  addsub_issue_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .OP_CNT_W      (OP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .au_in1   (au_in1),
    .au_in2   (au_in2),
    .au_op    (au_op),
    .au_out   (au_out),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected response from plain integer arithmetic on the lane values.
  function automatic void ref_rsp(input logic [7:0] a, input logic [7:0] c, input logic [1:0] op,
                                  output logic [7:0] d, output logic [1:0] o, output logic e);
    int x, y, s;
    d = '0;
    o = '0;
    e = (op > 2'd1);
    if (!e) begin
      for (int l = 0; l < 2; l++) begin
        x = int'($signed(a[l*4 +: 4]));
        y = int'($signed(c[l*4 +: 4]));
        s = (op == 2'd1) ? x - y : x + y;
        o[l] = (s > 7) || (s < -8);
`ifdef ADDSUB_SAT_EN
        if (s > 7) s = 7;
        else if (s < -8) s = -8;
`endif
        d[l*4 +: 4] = s[3:0];
      end
    end
  endfunction

  // Emulated downstream unit: lane-wise wrap-around add/sub.
  function automatic logic [7:0] unit_out(input logic [7:0] a, input logic [7:0] c, input logic [1:0] op);
    logic [7:0] r;
    int s;
    for (int l = 0; l < 2; l++) begin
      s = (op == 2'd1) ? int'(a[l*4 +: 4]) - int'(c[l*4 +: 4]) : int'(a[l*4 +: 4]) + int'(c[l*4 +: 4]);
      r[l*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

  // ---------------- model ----------------
  bit         started = 0;
  bit         m_inflight = 0;
  int         cyc = 0;
  int         m_ready_at = 0;
  int         m_count = 0;
  logic [7:0] m_au1 = '0, m_au2 = '0;
  logic [1:0] m_auop = '0;
  logic [7:0] m_pdata = '0, m_rdata = '0;
  logic [1:0] m_povf = '0, m_rovf = '0;
  logic       m_perr = 1'b0, m_rerr = 1'b0;

  initial au_out = '0;

  always @(posedge clk) begin
    bit rv, rr;
    rv = m_inflight && (cyc >= m_ready_at);
    rr = !rst && (!m_inflight || (rv && bus.rsp_ready));
    cyc = cyc + 1;
    if (rst) begin
      m_inflight = 0;
      m_count    = 0;
      m_au1      = '0;
      m_au2      = '0;
      m_auop     = '0;
      m_rdata    = '0;
      m_rovf     = '0;
      m_rerr     = 1'b0;
    end else begin
      if (rv && bus.rsp_ready) begin
        m_count    = (m_count + 1) % (1 << OP_W);
        m_inflight = 0;
      end
      if (bus.req_valid && rr) begin
        m_inflight = 1;
        m_ready_at = cyc + SETTLE;
        m_au1      = bus.req_in1;
        m_au2      = bus.req_in2;
        m_auop     = (bus.req_op > 2'd1) ? 2'd0 : bus.req_op;
        ref_rsp(bus.req_in1, bus.req_in2, bus.req_op, m_pdata, m_povf, m_perr);
      end
      if (m_inflight && cyc == m_ready_at) begin
        m_rdata = m_pdata;
        m_rovf  = m_povf;
        m_rerr  = m_perr;
      end
    end
    if (m_inflight && (cyc + 1 == m_ready_at))
      au_out <= unit_out(m_au1, m_au2, m_auop);
    else
      au_out <= 8'($urandom);
    started = 1;
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    bit rv, rr;
    if (started) begin
      rv = m_inflight && (cyc >= m_ready_at);
      rr = !rst && (!m_inflight || (rv && bus.rsp_ready));
      chk("req_ready", 32'(bus.req_ready), 32'(rr));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
      chk("busy",      32'(busy),          32'(m_inflight));
      chk("op_count",  32'(op_count),      32'(m_count));
      chk("au_in1",    32'(au_in1),        32'(m_au1));
      chk("au_in2",    32'(au_in2),        32'(m_au2));
      chk("au_op",     32'(au_op),         32'(m_auop));
      chk("rsp_data",  32'(bus.rsp_data),  32'(m_rdata));
      chk("rsp_ovf",   32'(bus.rsp_ovf),   32'(m_rovf));
      chk("rsp_err",   32'(bus.rsp_err),   32'(m_rerr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] c, input logic [1:0] op);
    int w;
    w = 0;
    bus.req_valid = 1'b1;
    bus.req_in1   = a;
    bus.req_in2   = c;
    bus.req_op    = op;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_in1   = 8'($urandom);
    bus.req_in2   = 8'($urandom);
    bus.req_op    = 2'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic directed(input string name, input logic [7:0] a, input logic [7:0] c,
                          input logic [1:0] op, input logic [7:0] ed, input logic [1:0] eo,
                          input logic ee);
    int lat;
    issue(a, c, op);
    chk({name, "_au_in1"}, 32'(au_in1), 32'(a));
    chk({name, "_au_op"}, 32'(au_op), (op > 2'd1) ? 32'd0 : 32'(op));
    wait_rsp(lat);
    $display("txn %s: in1=%02h in2=%02h op=%0d -> data=%02h ovf=%b err=%b latency=%0d",
             name, a, c, op, bus.rsp_data, bus.rsp_ovf, bus.rsp_err, lat);
    chk({name, "_latency"}, 32'(lat), 32'(SETTLE));
    chk({name, "_data"}, 32'(bus.rsp_data), 32'(ed));
    chk({name, "_ovf"}, 32'(bus.rsp_ovf), 32'(eo));
    chk({name, "_err"}, 32'(bus.rsp_err), 32'(ee));
  endtask

  logic [7:0] pd;
  logic [1:0] po;
  logic       pe;
  logic [7:0] exp_sub_data;

  initial begin
`ifdef ADDSUB_SAT_EN
    exp_sub_data = 8'h78;
`else
    exp_sub_data = 8'h87;
`endif
    bus.req_valid = 1'b0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;

    // Hand-computed pins on the reference model.
    ref_rsp(8'h35, 8'h21, 2'd0, pd, po, pe);
    chk("pin_add_data", 32'(pd), 32'h56);
    chk("pin_add_ovf", 32'(po), 32'h0);
    ref_rsp(8'h78, 8'hF1, 2'd1, pd, po, pe);
    chk("pin_sub_data", 32'(pd), 32'(exp_sub_data));
    chk("pin_sub_ovf", 32'(po), 32'h3);
    ref_rsp(8'h12, 8'h34, 2'd2, pd, po, pe);
    chk("pin_ill_err", 32'(pe), 32'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;

    directed("add",     8'h35, 8'h21, 2'd0, 8'h56, 2'b00, 1'b0);
    directed("sub_ovf", 8'h78, 8'hF1, 2'd1, exp_sub_data, 2'b11, 1'b0);
    directed("illegal", 8'h12, 8'h34, 2'd2, 8'h00, 2'b00, 1'b1);
    @(posedge clk);
    #1;

    // Backpressure then simultaneous response/request handshake.
    bus.rsp_ready = 1'b0;
    directed("bp", 8'h23, 8'h14, 2'd0, 8'h37, 2'b00, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data), 32'h37);
    end
    bus.rsp_ready = 1'b1;
    directed("b2b", 8'h11, 8'h22, 2'd0, 8'h33, 2'b00, 1'b0);
    chk("b2b_op_count", 32'(op_count), 32'd4);
    @(posedge clk);
    #1;

    // Reset while waiting on the unit.
    issue(8'h44, 8'h33, 2'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_au_in1", 32'(au_in1), 32'd0);
    chk("rstw_op_count", 32'(op_count), 32'd0);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    repeat (SETTLE + 3) begin
      @(posedge clk);
      #1;
      chk("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Counter wrap: 16 completions on a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a, c;
      logic [1:0] op;
      a  = 8'($urandom);
      c  = 8'($urandom);
      op = 2'($urandom_range(0, 1));
      ref_rsp(a, c, op, pd, po, pe);
      directed("wrap_txn", a, c, op, pd, po, pe);
    end
    @(posedge clk);
    #1;
    chk("wrap_op_count", 32'(op_count), 32'd0);

    // Random traffic, random backpressure, occasional reset.
    for (int i = 0; i < 800; i++) begin
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_in1   = 8'($urandom);
      bus.req_in2   = 8'($urandom);
      bus.req_op    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 149) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (SETTLE + 4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
